stream_mux_arb: RTL
===================

# stream_mux_arb

N-channel streaming multiplexer with valid/ready handshakes, a registered output stage and packet locking. It replaces fixed two-input select muxes in the access-control path wherever several producers share one consumer, such as GLB read ports feeding the PE-array data bus. It runs in one of two modes, chosen at runtime:

- **Select mode:** a software-chosen channel is forwarded.
- **Round-robin mode:** channels are served fairly in turn.

## Interface
Parameters:
- DATA_WIDTH, default 16: payload width per channel.
- NUM_CH, default 4: number of input channels; must be ≥ 2.
- SEL_W, default $clog2(NUM_CH): width of the channel index.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- mode, input, 1: 0 = select mode, 1 = round-robin mode. Sampled only in IDLE.
- sel, input, SEL_W: channel forwarded in select mode. Sampled only in IDLE.
- in_valid, input, NUM_CH: per-channel valid.
- in_last, input, NUM_CH: per-channel end-of-packet flag.
- in_data, input, NUM_CH×DATA_WIDTH: packed as [NUM_CH-1:0][DATA_WIDTH-1:0].
- in_ready, output, NUM_CH: per-channel ready; combinational.
- out_valid, output, 1: output register holds a beat.
- out_data, output, DATA_WIDTH: registered payload.
- out_last, output, 1: registered end-of-packet flag.
- out_ch, output, SEL_W: index of the channel the current beat came from.
- out_ready, input, 1: downstream ready.

## Operation
- **Transfers:**
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready.
- **Output register:** a single-entry register.
  - can_load = !out_valid | out_ready.
  - in_ready[i] = grant[i] & can_load. At most one bit of grant is ever set.
- **FSM states:** IDLE and LOCKED.
- **Grant in IDLE (combinational):**
  - Select mode: grant[sel] = in_valid[sel]. If sel ≥ NUM_CH, no grant, and in_ready stays all-zero.
  - Round-robin mode: grant goes to the first valid channel found searching upward from rr_ptr+1, wrapping modulo NUM_CH.
- **IDLE transitions:**
  - Transfer with in_last = 0: go to LOCKED, with lock_ch = the granted index.
  - Transfer with in_last = 1: stay in IDLE; the packet was a single beat.
- **LOCKED:**
  - grant[lock_ch] = in_valid[lock_ch]. All other channels see in_ready = 0.
  - mode and sel are ignored.
  - A transfer with in_last = 1 returns the FSM to IDLE.
- **rr_ptr:**
  - Updates to the channel index only when that channel's last beat is accepted.
  - Updates in both modes, so switching to round-robin continues fairly.
- **Load:** on an input transfer, out_data, out_last and out_ch are loaded and out_valid is set.
- **Output only:** an output transfer with no input transfer clears out_valid.
- **Simultaneous output and input transfer:** the register reloads in the same cycle and out_valid stays 1.
- **Payload ordering:** no reordering. Beats of a packet leave contiguous and in order.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready stays high.
- in_ready depends combinationally on in_valid, sel, mode, out_valid and out_ready. There are no combinational paths from in_* to out_*.
- Reset values: out_valid = 0, out_data = 0, out_last = 0, out_ch = 0, state = IDLE, rr_ptr = NUM_CH-1 (so channel 0 has first priority), lock_ch = 0.
- Reset asserted mid-packet: the packet is dropped. After release, arbitration restarts from the reset state.
- Backpressure (out_ready = 0 while out_valid = 1): in_ready is all-zero, and the output holds stable.
- A channel deasserting in_valid mid-packet while LOCKED: the lock holds and no other channel is served.

## Structure
- Package stream_mux_pkg:
  - mux_state_e enum {IDLE, LOCKED}.
  - MODE_SELECT = 1'b0 and MODE_RR = 1'b1 constants.
- Sub-module rr_arbiter:
  - Parameter NUM_CH.
  - Inputs: req, ptr, en.
  - Output: one-hot gnt plus gnt_idx.
  - Purely combinational priority rotation.
- The top level holds the FSM, the lock/pointer registers and the output register.

## Test plan
- **Select mode, NUM_CH=4, sel=2, all channels valid, single-beat packets, out_ready=1:**
  - Only in_ready[2] is high.
  - out_ch = 2 every cycle, with out_data following in_data[2] one cycle later.
- **Round-robin, all four valid, single-beat packets:**
  - out_ch sequence is 0,1,2,3,0,1 after reset.
  - One beat per cycle, with no bubbles.
- **Round-robin, channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is also valid:**
  - out_ch = 1 for 3 consecutive beats.
  - Channel 0 is served next.
- **Backpressure:**
  - Setup: out_ready=0 for 5 cycles while channel 0 holds data 0xABCD.
  - Required response: out_data remains 0xABCD, in_ready = 0000, and no beats are lost or duplicated when out_ready returns to 1.
- **sel=2 → sel=0 switch:**
  - Change sel during a locked channel-2 packet.
  - Channel 2 completes its packet first; channel 0 is granted only after IDLE is re-entered.
- **Reset mid-packet:**
  - Assert reset during beat 2 of 4.
  - All outputs become zero asynchronously, the state is IDLE, and channel 0 wins first in round-robin after release.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the streaming channel multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_e;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester found searching upward from ptr+1, wrapping.
// Latency: purely combinational, no state.
// Backpressure: none of its own; en=0 suppresses every grant.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    int   idx;
    logic found;

    // Walk the channels starting just after the last-served one; the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = (int'(ptr) + off) % NUM_CH;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = SEL_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 packet-locking stream mux (select or round-robin) with a single registered output stage.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: in_ready is all-zero while the output register is full and out_ready is low.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mode,
    input  logic [SEL_W-1:0]                     sel,
    input  logic [NUM_CH-1:0]                    in_valid,
    input  logic [NUM_CH-1:0]                    in_last,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    in_data,
    output logic [NUM_CH-1:0]                    in_ready,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_last,
    output logic [SEL_W-1:0]                     out_ch,
    input  logic                                 out_ready
);

    mux_state_e             state_q, state_d;
    logic [SEL_W-1:0]       lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [SEL_W-1:0]       out_ch_q, out_ch_d;

    logic [NUM_CH-1:0]      arb_gnt;
    logic [SEL_W-1:0]       arb_idx;
    logic                   arb_en;
    logic [NUM_CH-1:0]      grant;
    logic [SEL_W-1:0]       grant_idx;
    logic                   can_load;
    logic                   xfer;
    logic                   xfer_last;

    // Round-robin only chooses a new owner between packets.
    assign arb_en = (state_q == IDLE) && (mode == MODE_RR);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Pick the granted channel: the locked owner mid-packet, otherwise sel or the arbiter.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (state_q == LOCKED) begin
            grant_idx        = lock_ch_q;
            grant[lock_ch_q] = in_valid[lock_ch_q];
        end else if (mode == MODE_SELECT) begin
            // An out-of-range sel grants nobody.
            if (int'(sel) < NUM_CH) begin
                grant_idx  = sel;
                grant[sel] = in_valid[sel];
            end
        end else begin
            grant     = arb_gnt;
            grant_idx = arb_idx;
        end
    end

    assign can_load  = !out_valid_q || out_ready;
    assign in_ready  = grant & {NUM_CH{can_load}};
    assign xfer      = |in_ready;
    assign xfer_last = in_last[grant_idx];

    // Next-state: load the output register on a transfer, track packet lock and fairness pointer.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx];
            out_last_d  = xfer_last;
            out_ch_d    = grant_idx;
            if (xfer_last) begin
                // Packet done: release the lock and rotate priority past this channel.
                state_d  = IDLE;
                rr_ptr_d = grant_idx;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // All state registers; reset drops any packet in flight and gives channel 0 first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule
